// File: rtl/hazard_ctrl.sv
// Purpose : five-stage pipeline hazard sequencer; drives stall/flush/PC-write every cycle.
// Latency : controls are combinational from state, counters and inputs (same cycle).
// Backpr. : MEM_Wait freezes the whole pipe; load-use and MDU hazards stall IF/ID and bubble ID/EX.
//
// Ports:
//   reset, clk                  asynchronous active-high reset, rising-edge clock
//   ID_rs, ID_rt, ID_UsesRt     source registers of the ID instruction
//   ID_Jump, ID_MduRead         ID-stage jump and mfhi/mflo indicators
//   EX_MemRead, EX_rt           EX-stage load and its destination register
//   EX_BranchTaken              EX-stage branch resolved taken
//   EX_MduStart                 EX-stage mult/div start
//   MEM_Wait                    data memory not ready
//   PC_Write, IF_stall, IF_flush, ID_EX_flush, Pipe_freeze   pipeline controls
//   Mdu_busy                    HI/LO not yet valid
//   State                       00 BOOT, 01 RUN, 10 FREEZE
//   Stall_cycles, Flush_cycles  saturating performance counters
module hazard_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int BOOT_CYCLES = 2
) (
    input  logic        reset,
    input  logic        clk,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Jump,
    input  logic        ID_MduRead,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_BranchTaken,
    input  logic        EX_MduStart,
    input  logic        MEM_Wait,
    output logic        PC_Write,
    output logic        IF_stall,
    output logic        IF_flush,
    output logic        ID_EX_flush,
    output logic        Pipe_freeze,
    output logic        Mdu_busy,
    output logic [1:0]  State,
    output logic [31:0] Stall_cycles,
    output logic [31:0] Flush_cycles
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FREEZE = 2'b10
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] MDU_LOAD  = 8'(MDU_LATENCY);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  boot_cnt_q;
    logic [7:0]  mdu_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    logic load_use;
    logic mdu_hazard;

    assign Mdu_busy     = (mdu_cnt_q != 8'd0);
    assign State        = state_q;
    assign Stall_cycles = stall_cnt_q;
    assign Flush_cycles = flush_cnt_q;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                      ((EX_rt == ID_rs) || (ID_UsesRt && (EX_rt == ID_rt)));

    // A start sitting in EX right now counts as busy even before the counter loads.
    assign mdu_hazard = ID_MduRead && (Mdu_busy || EX_MduStart);

    // Next-state and control decode. FREEZE decodes exactly like RUN once
    // MEM_Wait drops, so both share one branch.
    always_comb begin
        state_d     = state_q;
        PC_Write    = 1'b0;
        IF_stall    = 1'b0;
        IF_flush    = 1'b0;
        ID_EX_flush = 1'b0;
        Pipe_freeze = 1'b0;

        case (state_q)
            ST_BOOT: begin
                IF_flush    = 1'b1;
                ID_EX_flush = 1'b1;
                if (boot_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (MEM_Wait) begin
                    // Pending branch/jump stays asserted upstream and is
                    // re-evaluated on the release cycle.
                    Pipe_freeze = 1'b1;
                    IF_stall    = 1'b1;
                    state_d     = ST_FREEZE;
                end else begin
                    state_d = ST_RUN;
                    if (EX_BranchTaken) begin
                        IF_flush    = 1'b1;
                        ID_EX_flush = 1'b1;
                        PC_Write    = 1'b1;
                    end else if (load_use || mdu_hazard) begin
                        IF_stall    = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (ID_Jump) begin
                        IF_flush = 1'b1;
                        PC_Write = 1'b1;
                    end else begin
                        PC_Write = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_INIT;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT && boot_cnt_q != 4'd0) begin
                boot_cnt_q <= boot_cnt_q - 4'd1;
            end
        end
    end

    // The MDU keeps counting through a freeze; only a new start is gated,
    // because a frozen EX instruction will be re-presented on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_cnt_q <= 8'd0;
        end else if (EX_MduStart && !Pipe_freeze) begin
            mdu_cnt_q <= MDU_LOAD;
        end else if (mdu_cnt_q != 8'd0) begin
            mdu_cnt_q <= mdu_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (state_q != ST_BOOT) begin
            if (IF_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IF_flush && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        reset;
    logic        clk;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_UsesRt;
    logic        ID_Jump;
    logic        ID_MduRead;
    logic        EX_MemRead;
    logic [4:0]  EX_rt;
    logic        EX_BranchTaken;
    logic        EX_MduStart;
    logic        MEM_Wait;
    logic        PC_Write;
    logic        IF_stall;
    logic        IF_flush;
    logic        ID_EX_flush;
    logic        Pipe_freeze;
    logic        Mdu_busy;
    logic [1:0]  State;
    logic [31:0] Stall_cycles;
    logic [31:0] Flush_cycles;

    int checks;
    int failures;

    hazard_ctrl #(
        .MDU_LATENCY(4),
        .BOOT_CYCLES(2)
    ) dut (
        .reset         (reset),
        .clk           (clk),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_UsesRt     (ID_UsesRt),
        .ID_Jump       (ID_Jump),
        .ID_MduRead    (ID_MduRead),
        .EX_MemRead    (EX_MemRead),
        .EX_rt         (EX_rt),
        .EX_BranchTaken(EX_BranchTaken),
        .EX_MduStart   (EX_MduStart),
        .MEM_Wait      (MEM_Wait),
        .PC_Write      (PC_Write),
        .IF_stall      (IF_stall),
        .IF_flush      (IF_flush),
        .ID_EX_flush   (ID_EX_flush),
        .Pipe_freeze   (Pipe_freeze),
        .Mdu_busy      (Mdu_busy),
        .State         (State),
        .Stall_cycles  (Stall_cycles),
        .Flush_cycles  (Flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       mdu_read;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       mem_wait;
        logic       pcw;
        logic       stall;
        logic       flush;
        logic       idex;
        logic       freeze;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
        ID_MduRead = 1'b0; EX_MemRead = 1'b0; EX_rt = 5'd0;
        EX_BranchTaken = 1'b0; EX_MduStart = 1'b0; MEM_Wait = 1'b0;
    endtask

    task automatic chk_ctl(input string name, input logic pcw, input logic stall,
                           input logic flush, input logic idex, input logic freeze,
                           input logic [1:0] st);
        chk({name, ".PC_Write"},    {31'd0, PC_Write},    {31'd0, pcw});
        chk({name, ".IF_stall"},    {31'd0, IF_stall},    {31'd0, stall});
        chk({name, ".IF_flush"},    {31'd0, IF_flush},    {31'd0, flush});
        chk({name, ".ID_EX_flush"}, {31'd0, ID_EX_flush}, {31'd0, idex});
        chk({name, ".Pipe_freeze"}, {31'd0, Pipe_freeze}, {31'd0, freeze});
        chk({name, ".State"},       {30'd0, State},       {30'd0, st});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        int exp_stall;
        int exp_flush;
        logic [31:0] base_stall;
        logic [31:0] base_flush;
        checks = 0;
        failures = 0;

        //                rs  rt  urt jmp mdr mrd ert br  mw  | pcw stl fls idx frz st
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0,  1, 0, 0, 0, 0, 2'b01};
        vecs[1]  = '{5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0, 0,  0, 1, 0, 1, 0, 2'b01};
        vecs[2]  = '{5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0,  1, 0, 0, 0, 0, 2'b01};
        vecs[3]  = '{5'd1, 5'd5, 1, 0, 0, 1, 5'd5, 0, 0,  0, 1, 0, 1, 0, 2'b01};
        vecs[4]  = '{5'd1, 5'd5, 0, 0, 0, 1, 5'd5, 0, 0,  1, 0, 0, 0, 0, 2'b01};
        vecs[5]  = '{5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 1, 0,  1, 0, 1, 1, 0, 2'b01};
        vecs[6]  = '{5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0,  1, 0, 1, 0, 0, 2'b01};
        vecs[7]  = '{5'd3, 5'd0, 0, 1, 0, 1, 5'd3, 0, 0,  0, 1, 0, 1, 0, 2'b01};
        vecs[8]  = '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0,  1, 0, 0, 0, 0, 2'b01};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1,  0, 1, 0, 0, 1, 2'b01};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1,  0, 1, 0, 0, 1, 2'b10};
        vecs[11] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0,  1, 0, 1, 1, 0, 2'b10};
        vecs[12] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0,  1, 0, 0, 0, 0, 2'b01};

        // Reset held for three rising edges; outputs follow the BOOT decode.
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_ctl("reset", 0, 0, 1, 1, 0, 2'b00);
        chk("reset.Stall_cycles", Stall_cycles, 32'd0);
        chk("reset.Flush_cycles", Flush_cycles, 32'd0);
        chk("reset.Mdu_busy", {31'd0, Mdu_busy}, 32'd0);

        // Two BOOT cycles after release, then RUN.
        next_cycle();
        reset = 1'b0;
        #1 chk_ctl("boot1", 0, 0, 1, 1, 0, 2'b00);
        next_cycle();
        #1 chk_ctl("boot2", 0, 0, 1, 1, 0, 2'b00);
        next_cycle();
        #1 chk_ctl("run0", 1, 0, 0, 0, 0, 2'b01);
        chk("boot.Stall_cycles", Stall_cycles, 32'd0);
        chk("boot.Flush_cycles", Flush_cycles, 32'd0);

        // Table-driven decode, one vector per cycle.
        base_stall = Stall_cycles;
        base_flush = Flush_cycles;
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            ID_rs = vecs[i].rs; ID_rt = vecs[i].rt; ID_UsesRt = vecs[i].uses_rt;
            ID_Jump = vecs[i].jump; ID_MduRead = vecs[i].mdu_read;
            EX_MemRead = vecs[i].mem_read; EX_rt = vecs[i].ex_rt;
            EX_BranchTaken = vecs[i].br; EX_MduStart = 1'b0; MEM_Wait = vecs[i].mem_wait;
            #1;
            chk_ctl($sformatf("vec%0d", i), vecs[i].pcw, vecs[i].stall, vecs[i].flush,
                    vecs[i].idex, vecs[i].freeze, vecs[i].st);
            chk($sformatf("vec%0d.excl", i), {31'd0, IF_stall & IF_flush}, 32'd0);
            exp_stall += int'(vecs[i].stall);
            exp_flush += int'(vecs[i].flush);
        end
        next_cycle();
        idle_inputs();
        #1;
        chk("table.Stall_cycles", Stall_cycles, base_stall + 32'(exp_stall));
        chk("table.Flush_cycles", Flush_cycles, base_flush + 32'(exp_flush));

        // Load-use plus taken branch: flush wins, Flush_cycles +1.
        base_flush = Flush_cycles;
        next_cycle();
        EX_MemRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8; EX_BranchTaken = 1'b1;
        #1 chk_ctl("lu_br", 1, 0, 1, 1, 0, 2'b01);
        next_cycle();
        idle_inputs();
        #1 chk("lu_br.Flush_cycles", Flush_cycles, base_flush + 32'd1);

        // MDU start with mfhi waiting in ID: stall cycles 0..4, release in 5.
        base_stall = Stall_cycles;
        next_cycle();
        EX_MduStart = 1'b1; ID_MduRead = 1'b1;
        #1 chk_ctl("mdu_c0", 0, 1, 0, 1, 0, 2'b01);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            EX_MduStart = 1'b0;
            #1;
            chk($sformatf("mdu_c%0d.IF_stall", c), {31'd0, IF_stall}, (c < 5) ? 32'd1 : 32'd0);
            chk($sformatf("mdu_c%0d.Mdu_busy", c), {31'd0, Mdu_busy}, (c < 5) ? 32'd1 : 32'd0);
        end
        chk("mdu.Stall_cycles", Stall_cycles, base_stall + 32'd5);

        // MEM_Wait for 3 cycles with a taken branch held.
        next_cycle();
        idle_inputs();
        EX_BranchTaken = 1'b1; MEM_Wait = 1'b1;
        #1 chk_ctl("mw0", 0, 1, 0, 0, 1, 2'b01);
        next_cycle();
        #1 chk_ctl("mw1", 0, 1, 0, 0, 1, 2'b10);
        next_cycle();
        #1 chk_ctl("mw2", 0, 1, 0, 0, 1, 2'b10);
        next_cycle();
        MEM_Wait = 1'b0;
        #1 chk_ctl("mw_rel", 1, 0, 1, 1, 0, 2'b10);
        next_cycle();
        EX_BranchTaken = 1'b0;
        #1 chk_ctl("mw_after", 1, 0, 0, 0, 0, 2'b01);

        // Reset asserted while frozen with the MDU busy.
        next_cycle();
        EX_MduStart = 1'b1;
        next_cycle();
        EX_MduStart = 1'b0; MEM_Wait = 1'b1;
        next_cycle();
        #1;
        chk("pre_rst.State", {30'd0, State}, 32'd2);
        chk("pre_rst.Mdu_busy", {31'd0, Mdu_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_ctl("mid_rst", 0, 0, 1, 1, 0, 2'b00);
        chk("mid_rst.Mdu_busy", {31'd0, Mdu_busy}, 32'd0);
        chk("mid_rst.Stall_cycles", Stall_cycles, 32'd0);
        chk("mid_rst.Flush_cycles", Flush_cycles, 32'd0);
        next_cycle();
        idle_inputs();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
